sha2_msg_packer: RTL and testbench

//  Parametrised successor of the SHA-2 message builder. Accepts a message as IN_W-bit beats
//  (MSB-first), packs the beats into 512-bit blocks, and applies SHA-256 padding: a '1' bit,

---
 rtl/sha2_msg_packer.sv | 233 +++++++++++++++++++++++
 tb/tb_sha2_msg_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_msg_packer.sv
// SHA-256 message packer: gathers IN_W-bit beats into 512-bit blocks and
// appends the SHA-256 padding (a '1' bit, zero fill, 64-bit length field).
// One accumulator plus one output register give a single block of slack
// against a stalled hash core.
module sha2_msg_packer #(
  parameter int IN_W  = 64,
  parameter int LEN_W = 64
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [LEN_W-1:0] cfg_size,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IN_W-1:0]  data_in,
  input  logic             data_in_last,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [511:0]     data_out,
  output logic             data_out_last,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             len_err
);

  localparam int BLK_W = 512;
  localparam int BEATS = BLK_W / IN_W;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int LOG_W = $clog2(IN_W);
  localparam int VB_W  = LOG_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_PAD, S_EXTRA, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] size_q, size_d;
  logic [BLK_W-1:0] acc_q, acc_d;
  logic             acc_full_q, acc_full_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_W:0]   total_q, total_d;
  logic [9:0]       bits_q, bits_d;
  logic [BLK_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             len_err_q, len_err_d;

  logic [63:0]      size_field;
  logic [LOG_W-1:0] size_rem;
  logic [VB_W-1:0]  vb;
  logic [IN_W-1:0]  last_mask;
  logic [LEN_W:0]   exp_beats;
  logic             out_free;
  logic             in_fire;
  logic             blk_done;
  logic [8:0]       beat_base;
  logic [8:0]       pad_idx;
  logic [BLK_W-1:0] work;
  logic [IN_W-1:0]  beat_w;

  // Length-derived constants for the current message.
  assign size_field = 64'(size_q);
  assign size_rem   = size_q[LOG_W-1:0];
  assign vb         = (size_rem == '0) ? VB_W'(IN_W) : {1'b0, size_rem};
  assign last_mask  = ~({IN_W{1'b1}} >> vb);
  assign exp_beats  = ({1'b0, size_q} + (LEN_W + 1)'(IN_W - 1)) >> LOG_W;

  // Handshake helpers: out can take a block if empty or draining this cycle.
  assign out_free      = !out_valid_q || data_out_ready;
  assign cfg_ready     = (state_q == S_IDLE);
  assign data_in_ready = (state_q == S_FILL) && (!acc_full_q || out_free);
  assign in_fire       = data_in_valid && data_in_ready;
  assign beat_base     = 9'(BLK_W - 1 - int'(beat_cnt_q) * IN_W);
  assign pad_idx       = 9'(BLK_W - 1 - int'(bits_q));

  assign data_out       = out_q;
  assign data_out_last  = out_last_q;
  assign data_out_valid = out_valid_q;
  assign len_err        = len_err_q;

  // Next-state, datapath and block-push logic.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    size_d      = size_q;
    acc_d       = acc_q;
    acc_full_d  = acc_full_q;
    beat_cnt_d  = beat_cnt_q;
    total_d     = total_q;
    bits_d      = bits_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    len_err_d   = 1'b0;
    blk_done    = 1'b0;
    work        = acc_q;
    beat_w      = data_in;

    if (out_valid_q && data_out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          size_d     = cfg_size;
          acc_d      = '0;
          acc_full_d = 1'b0;
          beat_cnt_d = '0;
          total_d    = '0;
          bits_d     = '0;
          state_d    = (cfg_size == '0) ? S_PAD : S_FILL;
        end
      end

      S_FILL: begin
        // A block parked in acc moves out first, freeing acc for this beat.
        if (acc_full_q && out_free) begin
          out_d       = acc_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          acc_full_d  = 1'b0;
          acc_d       = '0;
          work        = '0;
        end
        if (in_fire) begin
          if (data_in_last) beat_w = data_in & last_mask;
          work[beat_base -: IN_W] = beat_w;
          total_d  = total_q + 1'b1;
          blk_done = (beat_cnt_q == CNT_W'(BEATS - 1)) &&
                     (!data_in_last || vb == VB_W'(IN_W));
          if (blk_done) begin
            beat_cnt_d = '0;
            if (!acc_full_q && out_free) begin
              out_d       = work;
              out_valid_d = 1'b1;
              out_last_d  = 1'b0;
              acc_d       = '0;
            end else begin
              acc_d      = work;
              acc_full_d = 1'b1;
            end
          end else begin
            acc_d      = work;
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
          if (data_in_last) begin
            bits_d    = 10'(int'(beat_cnt_q) * IN_W + int'(vb));
            len_err_d = ((total_q + 1'b1) != exp_beats);
            state_d   = S_PAD;
          end
        end
      end

      S_PAD: begin
        if (bits_q == 10'd512) begin
          // Message ended on a block boundary: padding lives entirely in EXTRA.
          if (!acc_full_q || out_free) begin
            if (acc_full_q) begin
              out_d       = acc_q;
              out_valid_d = 1'b1;
              out_last_d  = 1'b0;
            end
            acc_d      = {1'b1, {(BLK_W - 65){1'b0}}, size_field};
            acc_full_d = 1'b0;
            state_d    = S_EXTRA;
          end
        end else if (out_free) begin
          work[pad_idx] = 1'b1;
          out_valid_d   = 1'b1;
          if (bits_q <= 10'd447) begin
            work[63:0] = size_field;
            out_d      = work;
            out_last_d = 1'b1;
            acc_d      = '0;
            state_d    = S_DONE;
          end else begin
            out_d      = work;
            out_last_d = 1'b0;
            acc_d      = {{(BLK_W - 64){1'b0}}, size_field};
            state_d    = S_EXTRA;
          end
        end
      end

      S_EXTRA: begin
        if (out_free) begin
          out_d       = acc_q;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          acc_d       = '0;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_free) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!nrst) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      // NOTE: the wide accumulator and output block are reset on purpose: a
      // mid-message reset must discard partial data and data_out reads zero.
      acc_q       <= '0;
      acc_full_q  <= 1'b0;
      beat_cnt_q  <= '0;
      total_q     <= '0;
      bits_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      acc_q       <= acc_d;
      acc_full_q  <= acc_full_d;
      beat_cnt_q  <= beat_cnt_d;
      total_q     <= total_d;
      bits_q      <= bits_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      len_err_q   <= len_err_d;
    end
  end

endmodule

// File: tb/tb_sha2_msg_packer.sv
// Self-checking bench for sha2_msg_packer (IN_W=64): directed cases plus
// randomized messages compared against a bit-queue SHA-256 padding model.
module tb_sha2_msg_packer;

  logic         clk;
  logic         nrst;
  logic [63:0]  cfg_size;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [63:0]  data_in;
  logic         data_in_last;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [511:0] data_out;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready;
  logic         len_err;

  int tests = 0;
  int fails = 0;

  logic [63:0]  stim_beats[$];
  logic [512:0] exp_q[$];
  logic [512:0] got[$];
  int n_last     = 0;
  int n_len_err  = 0;
  int n_in_ready = 0;

  sha2_msg_packer #(.IN_W(64), .LEN_W(64)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .cfg_size       (cfg_size),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .data_in        (data_in),
    .data_in_last   (data_in_last),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_last  (data_out_last),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .len_err        (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted output block and count pulse-type events.
  always @(posedge clk) begin
    if (nrst) begin
      if (data_out_valid && data_out_ready) begin
        got.push_back({data_out_last, data_out});
        if (data_out_last) n_last <= n_last + 1;
      end
      if (len_err) n_len_err <= n_len_err + 1;
      if (data_in_ready) n_in_ready <= n_in_ready + 1;
    end
  end

  task automatic check(input string tag, input logic [512:0] obs, input logic [512:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_tail(input string tag, input logic [512:0] exp);
    if (got.size() > 0) check(tag, got[got.size() - 1], exp);
    else begin
      tests++;
      fails++;
      $error("FAIL %s observed=no block expected=%h", tag, exp);
    end
  endtask

  task automatic fill_random(input int n);
    stim_beats.delete();
    for (int i = 0; i < n; i++) stim_beats.push_back({$urandom, $urandom});
  endtask

  // Reference: message bits (last beat trimmed to the size remainder), then
  // '1', zeros to 448 mod 512, 64-bit size; cut into MSB-first blocks.
  function automatic void build_expected(input int size, input int nbeats);
    bit           bits[$];
    int           len;
    int           nblk;
    logic [63:0]  sz;
    logic [63:0]  w;
    logic [511:0] blk;
    exp_q.delete();
    sz  = 64'(size);
    len = 0;
    if (nbeats > 0) len = (nbeats - 1) * 64 + ((size % 64 == 0) ? 64 : size % 64);
    for (int i = 0; i < len; i++) begin
      w = stim_beats[i / 64];
      bits.push_back(w[63 - (i % 64)]);
    end
    bits.push_back(1'b1);
    while (bits.size() % 512 != 448) bits.push_back(1'b0);
    for (int i = 63; i >= 0; i--) bits.push_back(sz[i]);
    nblk = bits.size() / 512;
    for (int k = 0; k < nblk; k++) begin
      for (int j = 0; j < 512; j++) blk[511 - j] = bits[k * 512 + j];
      exp_q.push_back({(k == nblk - 1), blk});
    end
  endfunction

  // mode 0: sink always ready, source never idles; mode 1: random bubbles on
  // both sides; mode 2: sink stalls 12 cycles once the first block appears.
  task automatic run_msg(input int size, input int nbeats, input int mode, input string tag);
    int base, last0, err0, rdy0, sent, cyc, stalls, hold, exp_err;
    bit seen_first, prev_fire;
    logic [511:0] held;
    base = got.size(); last0 = n_last; err0 = n_len_err; rdy0 = n_in_ready;
    sent = 0; cyc = 0; stalls = 0; hold = 0; seen_first = 0; prev_fire = 0; held = '0;
    build_expected(size, nbeats);
    exp_err = (nbeats != (size + 63) / 64) ? 1 : 0;

    @(negedge clk);
    data_out_ready = 1'b1;
    cfg_size  = 64'(size);
    cfg_valid = 1'b1;
    #1 check({tag, "_cfg_ready_idle"}, 513'(cfg_ready), 513'(1));
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_size  = '0;
    check({tag, "_cfg_ready_busy"}, 513'(cfg_ready), 513'(0));

    while (n_last == last0 && cyc < 3000) begin
      if (prev_fire) data_in_valid = 1'b0;
      if (!data_in_valid && sent < nbeats)
        data_in_valid = (mode != 1) || ($urandom_range(0, 3) != 0);
      if (data_in_valid) begin
        data_in      = stim_beats[sent];
        data_in_last = (sent == nbeats - 1);
      end else begin
        data_in      = {$urandom, $urandom};
        data_in_last = 1'($urandom_range(0, 1));
      end
      if (mode == 2 && !seen_first && data_out_valid) begin
        seen_first = 1'b1;
        held       = data_out;
        hold       = 12;
      end
      if (mode == 1) data_out_ready = 1'($urandom_range(0, 1));
      else if (hold > 0) begin
        data_out_ready = 1'b0;
        if (hold < 12)
          check($sformatf("%s_hold_stable%0d", tag, hold), {data_out_valid, data_out}, {1'b1, held});
      end else data_out_ready = 1'b1;
      #1;
      if (mode == 2 && hold == 1) check({tag, "_bp_in_ready"}, 513'(data_in_ready), 513'(0));
      if (hold > 0) hold--;
      if (mode == 0 && data_in_valid && !data_in_ready) stalls++;
      prev_fire = data_in_valid && data_in_ready;
      if (prev_fire) sent++;
      @(negedge clk);
      cyc++;
    end
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;

    check({tag, "_last_seen"}, 513'(n_last - last0), 513'(1));
    check({tag, "_beats_taken"}, 513'(sent), 513'(nbeats));
    check({tag, "_nblk"}, 513'(got.size() - base), 513'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got.size()) check($sformatf("%s_blk%0d", tag, i), got[base + i], exp_q[i]);
    check({tag, "_len_err"}, 513'(n_len_err - err0), 513'(exp_err));
    if (mode == 0) check({tag, "_stalls"}, 513'(stalls), 513'(0));
    if (nbeats == 0) check({tag, "_no_in_ready"}, 513'(n_in_ready - rdy0), 513'(0));
    check({tag, "_back_idle"}, {511'(0), cfg_ready, data_out_valid}, {511'(0), 2'b10});
  endtask

  initial begin
    int size, n;
    nrst = 1'b0; cfg_valid = 1'b0; cfg_size = '0; data_in = '0;
    data_in_last = 1'b0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {data_out_last, data_out},
          {1'b0, 512'(0)});
    check("rst_flags", {509'(0), cfg_ready, data_in_ready, data_out_valid, len_err},
          {509'(0), 4'b1000});
    @(negedge clk);
    nrst = 1'b1;

    stim_beats.delete();
    stim_beats.push_back(64'h6162630000000000);
    run_msg(24, 1, 0, "c1");
    check_tail("c1_const", {1'b1, 32'h61626380, 416'b0, 64'h18});

    stim_beats.delete();
    run_msg(0, 0, 0, "c2");
    check_tail("c2_const", {1'b1, 32'h80000000, 480'b0});

    fill_random(7);
    run_msg(448, 7, 0, "c3");
    check_tail("c3_const", {1'b1, 448'b0, 64'h1C0});

    fill_random(8);
    run_msg(512, 8, 0, "c4");
    check_tail("c4_const", {1'b1, 1'b1, 447'b0, 64'h200});

    fill_random(16);
    run_msg(1024, 16, 2, "c5");

    fill_random(2);
    run_msg(448, 2, 0, "c6");

    // Reset in the middle of a message after three beats.
    fill_random(3);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_size = 64'd448; data_out_ready = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      data_in_valid = 1'b1; data_in = stim_beats[k]; data_in_last = 1'b0;
      @(negedge clk);
    end
    data_in_valid = 1'b0;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_flags", {509'(0), cfg_ready, data_in_ready, data_out_valid, len_err},
          {509'(0), 4'b1000});
    check("midrst_data", {data_out_last, data_out}, 513'(0));
    @(negedge clk);
    nrst = 1'b1;

    stim_beats.delete();
    stim_beats.push_back(64'h6162630000000000);
    run_msg(24, 1, 0, "c6_after_rst");
    check_tail("c6_after_rst_const", {1'b1, 32'h61626380, 416'b0, 64'h18});

    for (int r = 0; r < 14; r++) begin
      size = (r == 0) ? 0 : $urandom_range(1, 1400);
      n    = (size + 63) / 64;
      fill_random(n);
      run_msg(size, n, (r % 3 == 2) ? 0 : 1, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
